pfa_seq64: RTL



---
 rtl/pfa_seq64.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pfa_seq64.sv
// pfa_seq64: wide adder that streams 16-bit slices, LSB first, through one shared pfa16.
// Optional subtract mode is enabled by defining PFA_SEQ_SUB_EN (adds the op port).
module pfa16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    // Kogge-Stone tree; cin is folded into the bit-0 generate so every carry falls out of the tree.
    function automatic logic [16:0] prefix_add(input logic [15:0] xa, input logic [15:0] ya,
                                               input logic ci);
        logic [15:0] hp, g, p, gn, pn;
        hp = xa ^ ya;
        g  = xa & ya;
        p  = hp;
        g[0] = g[0] | (hp[0] & ci);
        for (int l = 0; l < 4; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < 16; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        return {g[15], hp ^ {g[14:0], ci}};
    endfunction

    assign {cout, s} = prefix_add(x, y, cin);
endmodule

module pfa_seq64 #(
    parameter int NSLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*NSLICE-1:0] a,
    input  logic [16*NSLICE-1:0] b,
    input  logic                 cin,
`ifdef PFA_SEQ_SUB_EN
    input  logic                 op,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*NSLICE-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 16 * NSLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k;
    logic            carry;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic [W-1:0]    b_in_eff;
    logic            carry_init;
    logic [KW+3:0]   base;
    logic [15:0]     slice_s;
    logic            slice_cout;

`ifdef PFA_SEQ_SUB_EN
    // Subtract as a + ~b + 1: the forced carry replaces cin.
    assign b_in_eff   = op ? ~b : b;
    assign carry_init = op | cin;
`else
    assign b_in_eff   = b;
    assign carry_init = cin;
`endif

    assign base = {k, 4'd0};

    pfa16 u_pfa16 (
        .x    (a_q[base +: 16]),
        .y    (b_q[base +: 16]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b_in_eff;
                    carry <= carry_init;
                    k     <= '0;
                end
                RUN: begin
                    sum_q[base +: 16] <= slice_s;
                    carry             <= slice_cout;
                    if (k != K_LAST) k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = out_valid & carry;
    assign ovf       = out_valid & (a_q[W-1] == b_q[W-1]) & (sum_q[W-1] != a_q[W-1]);
endmodule
